// File: rtl/hamming_pkg.sv
// Shared (71,64) Hamming definitions: widths, codeword type, scatter/gather maps
// and the parity helper used by both the encoder and the decoder.
package hamming_pkg;

    localparam int DATA_W = 64;
    localparam int CW_W   = 71;
    localparam int NPAR   = 7;

    typedef logic [CW_W:1] codeword_t;

    // Codeword position of data bit i (1..DATA_W); parity slots 2^k are skipped.
    function automatic int unsigned data_pos(input int unsigned i);
        int unsigned pos;
        if (i <= 32'd1) begin
            pos = 32'd3;
        end else if (i <= 32'd4) begin
            pos = i + 32'd3;
        end else if (i <= 32'd11) begin
            pos = i + 32'd4;
        end else if (i <= 32'd26) begin
            pos = i + 32'd5;
        end else if (i <= 32'd57) begin
            pos = i + 32'd6;
        end else begin
            pos = i + 32'd7;
        end
        return pos;
    endfunction

    function automatic codeword_t scatter(input logic [DATA_W:1] d);
        codeword_t cw;
        cw = '0;
        for (int unsigned i = 1; i <= DATA_W; i++) begin
            cw[data_pos(i)] = d[i];
        end
        return cw;
    endfunction

    function automatic logic [DATA_W:1] gather(input codeword_t cw);
        logic [DATA_W:1] d;
        d = '0;
        for (int unsigned i = 1; i <= DATA_W; i++) begin
            d[i] = cw[data_pos(i)];
        end
        return d;
    endfunction

    // Bit k is the XOR of every position whose index has bit k set.
    function automatic logic [NPAR-1:0] parity_calc(input codeword_t cw);
        logic [NPAR-1:0] p;
        p = '0;
        for (int k = 0; k < NPAR; k++) begin
            for (int j = 1; j <= CW_W; j++) begin
                if (j[k]) begin
                    p[k] = p[k] ^ cw[j];
                end
            end
        end
        return p;
    endfunction

    // One-hot flip mask; out-of-range positions give an all-zero mask.
    function automatic codeword_t inj_mask(input logic [NPAR:1] pos);
        codeword_t m;
        m = '0;
        for (int j = 1; j <= CW_W; j++) begin
            m[j] = (pos == NPAR'(j));
        end
        return m;
    endfunction

endpackage

// File: rtl/hamming_parity_gen.sv
// Combinational parity fill: input has data scattered and parity slots zero,
// output has the seven even-parity bits placed at positions 1,2,4,...,64.
module hamming_parity_gen
    import hamming_pkg::*;
(
    input  logic [71:1] data_cw,
    output logic [71:1] cw
);

    logic [NPAR-1:0] par_s;

    // Insert computed parity into the power-of-two positions.
    always_comb begin
        par_s = parity_calc(data_cw);
        cw    = data_cw;
        for (int k = 0; k < NPAR; k++) begin
            cw[1 << k] = par_s[k];
        end
    end

endmodule

// File: rtl/hamming_encoder_pipe.sv
// Two-stage pipelined (71,64) Hamming encoder with valid/ready on both sides.
// Define HAMMING_ENC_ERRINJ_EN to add the inj_pos single-bit error injection port.
module hamming_encoder_pipe
    import hamming_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [64:1]      din,
`ifdef HAMMING_ENC_ERRINJ_EN
    input  logic [7:1]       inj_pos,
`endif
    input  logic             in_valid,
    output logic             in_ready,
    output logic [71:1]      codeword,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CNT_W-1:0] word_count
);

    logic             s1_valid_r;
    codeword_t        s1_data_r;
    logic [NPAR:1]    s1_inj_r;
    logic             out_valid_r;
    codeword_t        codeword_r;
    logic [CNT_W-1:0] word_count_r;

    logic             s2_load_s;
    logic             s1_load_s;
    logic [NPAR:1]    inj_in_s;
    codeword_t        par_cw_s;
    codeword_t        enc_cw_s;

    // Each stage loads when empty or when the stage below it advances.
    always_comb begin
        s2_load_s = !out_valid_r || out_ready;
        s1_load_s = !s1_valid_r || s2_load_s;
    end

`ifdef HAMMING_ENC_ERRINJ_EN
    assign inj_in_s = inj_pos;
`else
    assign inj_in_s = {NPAR{1'b0}};
`endif

    // Stage 1: scattered data, valid flag and injection position.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_r <= 1'b0;
            s1_data_r  <= '0;
            s1_inj_r   <= {NPAR{1'b0}};
        end else if (s1_load_s) begin
            s1_valid_r <= in_valid;
            if (in_valid) begin
                s1_data_r <= scatter(din);
                s1_inj_r  <= inj_in_s;
            end else begin
                s1_data_r <= s1_data_r;
                s1_inj_r  <= s1_inj_r;
            end
        end else begin
            s1_valid_r <= s1_valid_r;
        end
    end

    hamming_parity_gen u_parity_gen (
        .data_cw (s1_data_r),
        .cw      (par_cw_s)
    );

    // Injection happens after parity so the decoder sees a genuine single-bit error.
    always_comb begin
        enc_cw_s = par_cw_s ^ inj_mask(s1_inj_r);
    end

    // Stage 2: completed codeword and output valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_r <= 1'b0;
            codeword_r  <= '0;
        end else if (s2_load_s) begin
            out_valid_r <= s1_valid_r;
            if (s1_valid_r) begin
                codeword_r <= enc_cw_s;
            end else begin
                codeword_r <= codeword_r;
            end
        end else begin
            out_valid_r <= out_valid_r;
        end
    end

    // Emitted-word counter, wraps naturally at 2^CNT_W.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            word_count_r <= {CNT_W{1'b0}};
        end else if (out_valid_r && out_ready) begin
            word_count_r <= word_count_r + CNT_W'(1);
        end else begin
            word_count_r <= word_count_r;
        end
    end

    assign in_ready   = s1_load_s;
    assign codeword   = codeword_r;
    assign out_valid  = out_valid_r;
    assign word_count = word_count_r;

endmodule

// File: tb/tb_hamming_encoder_pipe.sv
// Directed self-checking bench for hamming_encoder_pipe (counter narrowed to 3 bits
// so wrap-around is reached quickly).
module tb_hamming_encoder_pipe;

    localparam int CW = 3;

    logic          clk;
    logic          rst_n;
    logic [64:1]   din;
    logic          in_valid;
    logic          in_ready;
    logic [71:1]   codeword;
    logic          out_valid;
    logic          out_ready;
    logic [CW-1:0] word_count;
`ifdef HAMMING_ENC_ERRINJ_EN
    logic [7:1]    inj_pos;
`endif

    int checks_cnt;
    int errors_cnt;

    hamming_encoder_pipe #(.CNT_W(CW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .din        (din),
`ifdef HAMMING_ENC_ERRINJ_EN
        .inj_pos    (inj_pos),
`endif
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .codeword   (codeword),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .word_count (word_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks_cnt++;
        if (obs !== exp) begin
            errors_cnt++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Send one word with out_ready high; return what appears two cycles later.
    task automatic run_word(input logic [64:1] d, input logic [7:1] ip,
                            output logic [71:1] cw, output logic vld);
        @(negedge clk);
        din       = d;
`ifdef HAMMING_ENC_ERRINJ_EN
        inj_pos   = ip;
`else
        if (ip != 7'd0) $display("note: injection requested without HAMMING_ENC_ERRINJ_EN");
`endif
        in_valid  = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        cw  = codeword;
        vld = out_valid;
        @(posedge clk);
    endtask

    logic [71:1] cw_o;
    logic        vld_o;
    logic [64:1] rnd_d;

    initial begin
        checks_cnt = 0;
        errors_cnt = 0;
        rst_n      = 1'b0;
        din        = 64'h0;
        in_valid   = 1'b0;
        out_ready  = 1'b0;
`ifdef HAMMING_ENC_ERRINJ_EN
        inj_pos    = 7'd0;
`endif
        #12;
        check("rst_out_valid", 128'(out_valid), 128'(1'b0));
        check("rst_codeword", 128'(codeword), 128'(71'h0));
        check("rst_count", 128'(word_count), 128'(3'd0));
        check("rst_in_ready", 128'(in_ready), 128'(1'b1));
        @(negedge clk);
        rst_n = 1'b1;

        // All-zeros word, with a latency probe one cycle after acceptance.
        @(negedge clk);
        din = 64'h0; in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        check("lat_not_early", 128'(out_valid), 128'(1'b0));
        @(negedge clk);
        check("zero_valid", 128'(out_valid), 128'(1'b1));
        check("zero_cw", 128'(codeword), 128'(71'h0));
        @(negedge clk);
        check("zero_count", 128'(word_count), 128'(3'd1));
        check("zero_drained", 128'(out_valid), 128'(1'b0));

        // Back-to-back at full throughput: lowest then highest data bit.
        din = 64'h1; in_valid = 1'b1;
        @(negedge clk);
        din = 64'h8000_0000_0000_0000;
        @(negedge clk);
        in_valid = 1'b0;
        check("lo_valid", 128'(out_valid), 128'(1'b1));
        check("lo_cw", 128'(codeword), 128'(71'h7));
        @(negedge clk);
        check("hi_valid", 128'(out_valid), 128'(1'b1));
        check("hi_cw", 128'(codeword), 128'(71'h40_8000_0000_0000_000B));
        @(negedge clk);
        check("tput_count", 128'(word_count), 128'(3'd3));

        // Backpressure: A=1, B=din[2] (cw 0x19), C=3 (cw 0x1E).
        out_ready = 1'b0; in_valid = 1'b1; din = 64'h1;
        check("bp_rdy_a", 128'(in_ready), 128'(1'b1));
        @(negedge clk);
        din = 64'h2;
        check("bp_rdy_b", 128'(in_ready), 128'(1'b1));
        @(negedge clk);
        din = 64'h3;
        check("bp_rdy_c", 128'(in_ready), 128'(1'b0));
        check("bp_cw_a", 128'(codeword), 128'(71'h7));
        @(negedge clk);
        check("bp_hold_rdy", 128'(in_ready), 128'(1'b0));
        check("bp_stable", 128'(codeword), 128'(71'h7));
        check("bp_hold_vld", 128'(out_valid), 128'(1'b1));
        out_ready = 1'b1;
        #1;
        check("bp_release_rdy", 128'(in_ready), 128'(1'b1));
        @(negedge clk);
        in_valid = 1'b0;
        check("bp_cw_b", 128'(codeword), 128'(71'h19));
        @(negedge clk);
        check("bp_cw_c", 128'(codeword), 128'(71'h1E));
        @(negedge clk);
        check("bp_drained", 128'(out_valid), 128'(1'b0));
        check("bp_count", 128'(word_count), 128'(3'd6));

        // Counter wrap at 2^3.
        run_word(64'h2, 7'd0, cw_o, vld_o);
        check("wrap_cw", 128'(cw_o), 128'(71'h19));
        @(negedge clk);
        check("wrap_count7", 128'(word_count), 128'(3'd7));
        run_word(64'h3, 7'd0, cw_o, vld_o);
        check("wrap_vld", 128'(vld_o), 128'(1'b1));
        @(negedge clk);
        check("wrap_count0", 128'(word_count), 128'(3'd0));

        // Reset mid-flight with two words stalled in the pipe.
        out_ready = 1'b0; in_valid = 1'b1; din = 64'h1;
        @(negedge clk);
        din = 64'h2;
        @(negedge clk);
        in_valid = 1'b0;
        check("mid_full", 128'(out_valid), 128'(1'b1));
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_async_vld", 128'(out_valid), 128'(1'b0));
        check("mid_async_cnt", 128'(word_count), 128'(3'd0));
        @(negedge clk);
        rst_n = 1'b1; out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("mid_no_ghost", 128'(out_valid), 128'(1'b0));
        end
        run_word(64'h3, 7'd0, cw_o, vld_o);
        check("mid_fresh_vld", 128'(vld_o), 128'(1'b1));
        check("mid_fresh_cw", 128'(cw_o), 128'(71'h1E));
        @(negedge clk);
        check("mid_fresh_cnt", 128'(word_count), 128'(3'd1));

`ifdef HAMMING_ENC_ERRINJ_EN
        run_word(64'h0, 7'd5, cw_o, vld_o);
        check("inj5", 128'(cw_o), 128'(71'h10));
        run_word(64'h0, 7'd0, cw_o, vld_o);
        check("inj0", 128'(cw_o), 128'(71'h0));
        run_word(64'h0, 7'd72, cw_o, vld_o);
        check("inj72", 128'(cw_o), 128'(71'h0));
        rnd_d = {$urandom, $urandom};
        run_word(rnd_d, 7'd71, cw_o, vld_o);
        begin
            logic [6:0]  syn;
            logic [64:1] dec;
            int          n;
            syn = 7'd0;
            for (int j = 1; j <= 71; j++) begin
                if (cw_o[j]) syn = syn ^ 7'(j);
            end
            check("inj71_syndrome", 128'(syn), 128'(7'd71));
            cw_o[syn] = ~cw_o[syn];
            n = 1;
            dec = 64'h0;
            for (int j = 3; j <= 71; j++) begin
                if ((j & (j - 1)) != 0) begin
                    dec[n] = cw_o[j];
                    n++;
                end
            end
            check("inj71_decoded", 128'(dec), 128'(rnd_d));
        end
`else
        rnd_d = 64'h0;
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks_cnt, errors_cnt);
        $finish;
    end

endmodule
